// File: rtl/class_score_accumulator.sv
// class_score_accumulator
//   Streams one unsigned feature per beat together with N_CLASSES signed
//   weights and accumulates N_CLASSES saturating signed scores. After
//   N_INPUTS accepted beats the scores are held on Num with NumValid high
//   until the next Start. Num feeds the argmax stage directly.
//
// Ports
//   clk          system clock, rising edge
//   GlobalReset  synchronous active-high reset (priority over Start)
//   Start        single-cycle request to begin an accumulation (IDLE/DONE only)
//   PixelValid   Pixel/Weights valid this cycle
//   Pixel        unsigned feature, PIX_W bits
//   Weights      signed weights, class k at [k*WGT_W +: WGT_W]
//   PixelReady   beat accepted this cycle when PixelValid is also high
//   Num          scores, class k at [k*SCORE_W +: SCORE_W], registered
//   NumValid     Num holds a complete result
//   Busy         accumulation in progress
module class_score_accumulator #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 26,
  parameter int PIX_W     = 8,
  parameter int WGT_W     = 8,
  parameter int N_INPUTS  = 784,
  parameter int CNT_W     = 10
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic                         Start,
  input  logic                         PixelValid,
  input  logic [PIX_W-1:0]             Pixel,
  input  logic [N_CLASSES*WGT_W-1:0]   Weights,
  output logic                         PixelReady,
  output logic [N_CLASSES*SCORE_W-1:0] Num,
  output logic                         NumValid,
  output logic                         Busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam int PROD_W = PIX_W + WGT_W + 1;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [N_CLASSES-1:0][SCORE_W-1:0]   acc_q, acc_d;

  logic beat_ok, last_beat, clear;

  assign beat_ok   = (state_q == S_ACCUM) && PixelValid;
  assign last_beat = (cnt_q == CNT_W'(N_INPUTS - 1));
  // Start only counts outside ACCUM; a beat in the same cycle is dropped
  // because PixelReady is low there.
  assign clear     = (state_q != S_ACCUM) && Start;

  // State register
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_ACCUM;
      S_ACCUM: if (PixelValid && last_beat) state_d = S_DONE;
      S_DONE:  if (Start) state_d = S_ACCUM;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: counter and saturating accumulators
  always_comb begin
    logic signed [WGT_W-1:0]  wgt;
    logic signed [PROD_W-1:0] prod;
    logic signed [SCORE_W:0]  sum;
    cnt_d = cnt_q;
    acc_d = acc_q;
    wgt   = '0;
    prod  = '0;
    sum   = '0;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (beat_ok) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < N_CLASSES; k++) begin
        wgt  = Weights[k*WGT_W +: WGT_W];
        prod = $signed({1'b0, Pixel}) * wgt;
        sum  = $signed(acc_q[k]) + prod;
        // One guard bit: top two bits disagree only on overflow.
        if (sum[SCORE_W] != sum[SCORE_W-1])
          acc_d[k] = sum[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}}
                                  : {1'b0, {(SCORE_W-1){1'b1}}};
        else
          acc_d[k] = sum[SCORE_W-1:0];
      end
    end
  end

  // Outputs
  always_comb begin
    PixelReady = (state_q == S_ACCUM);
    Busy       = (state_q == S_ACCUM);
    NumValid   = (state_q == S_DONE);
  end

  assign Num = acc_q;

endmodule

// File: tb/tb_class_score_accumulator.sv
module tb_class_score_accumulator;

  localparam int NC = 10;
  localparam int SW = 26;
  localparam int NB = NC * SW;
  localparam longint SMAX = 33554431;
  localparam longint SMIN = -33554432;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    start;
  logic          pv;
  logic [7:0]    pix;
  logic [79:0]   w;

  logic [NB-1:0] num_s, num_b;
  logic          nv_s, nv_b, bz_s, bz_b, pr_s, pr_b;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // small instance for functional runs, large one reaches saturation
  class_score_accumulator #(.N_INPUTS(4), .CNT_W(10)) u_small (
    .clk(clk), .GlobalReset(rst), .Start(start[0]), .PixelValid(pv),
    .Pixel(pix), .Weights(w), .PixelReady(pr_s), .Num(num_s),
    .NumValid(nv_s), .Busy(bz_s));

  class_score_accumulator #(.N_INPUTS(1100), .CNT_W(11)) u_big (
    .clk(clk), .GlobalReset(rst), .Start(start[1]), .PixelValid(pv),
    .Pixel(pix), .Weights(w), .PixelReady(pr_b), .Num(num_b),
    .NumValid(nv_b), .Busy(bz_b));

  // reference model: 0 idle, 1 accumulating, 2 done
  int     mode[2];
  int     cnt[2];
  longint sc[2][NC];
  int     nin[2] = '{4, 1100};
  int     wv[NC];

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack(input int d);
    logic [NB-1:0]      r;
    logic signed [63:0] t;
    r = '0;
    for (int k = 0; k < NC; k++) begin
      t = sc[d][k];
      r[k*SW +: SW] = t[SW-1:0];
    end
    return r;
  endfunction

  task automatic apply_w();
    for (int k = 0; k < NC; k++) w[k*8 +: 8] = 8'(wv[k]);
  endtask

  task automatic model_edge();
    logic signed [7:0] wk;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mode[d] = 0; cnt[d] = 0;
        for (int k = 0; k < NC; k++) sc[d][k] = 0;
      end else if (mode[d] != 1) begin
        if (start[d]) begin
          mode[d] = 1; cnt[d] = 0;
          for (int k = 0; k < NC; k++) sc[d][k] = 0;
        end
      end else if (pv) begin
        for (int k = 0; k < NC; k++) begin
          wk = w[k*8 +: 8];
          sc[d][k] = sc[d][k] + longint'(pix) * longint'(wk);
          if (sc[d][k] > SMAX) sc[d][k] = SMAX;
          if (sc[d][k] < SMIN) sc[d][k] = SMIN;
        end
        if (cnt[d] == nin[d] - 1) mode[d] = 2;
        cnt[d]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("num_s",  num_s, pack(0));
    chk("valid_s", NB'(nv_s), NB'(mode[0] == 2));
    chk("busy_s",  NB'(bz_s), NB'(mode[0] == 1));
    chk("ready_s", NB'(pr_s), NB'(mode[0] == 1));
    chk("num_b",  num_b, pack(1));
    chk("valid_b", NB'(nv_b), NB'(mode[1] == 2));
    chk("busy_b",  NB'(bz_b), NB'(mode[1] == 1));
    chk("ready_b", NB'(pr_b), NB'(mode[1] == 1));
  endtask

  task automatic rand_beat();
    pix = 8'($urandom);
    for (int k = 0; k < NC; k++)
      case ($urandom_range(3))
        0: wv[k] = 127;
        1: wv[k] = -128;
        default: wv[k] = $urandom_range(255) - 128;
      endcase
    apply_w();
  endtask

  initial begin
    logic [SW-1:0] expv;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; cnt[d] = 0;
      for (int k = 0; k < NC; k++) sc[d][k] = 0;
    end
    rst = 1'b1; start = '0; pv = 1'b0; pix = '0; w = '0;

    // reset hold with random inputs
    for (int i = 0; i < 2; i++) begin
      rand_beat(); start = 2'($urandom); pv = 1'($urandom);
      step();
    end
    rst = 1'b0; start = '0; pv = 1'b0;
    step();

    // basic accumulation: pixel 2, W[k]=k
    start = 2'b01; step(); start = '0;
    for (int k = 0; k < NC; k++) wv[k] = k;
    apply_w(); pix = 8'd2; pv = 1'b1;
    repeat (4) step();
    pv = 1'b0;
    chk("t2_score9", NB'(num_s[9*SW +: SW]), NB'(72));
    chk("t2_score4", NB'(num_s[4*SW +: SW]), NB'(32));
    step();

    // negative weight with stalls
    start = 2'b01; step(); start = '0;
    for (int k = 0; k < NC; k++) wv[k] = 0;
    wv[3] = -128; apply_w(); pix = 8'd255;
    for (int i = 0; i < 8; i++) begin
      pv = (i % 2 == 0);
      step();
    end
    pv = 1'b0;
    expv = SW'(-130560);
    chk("t3_score3", NB'(num_s[3*SW +: SW]), NB'(expv));
    step();

    // saturation on the large instance
    start = 2'b10; step(); start = '0;
    for (int k = 0; k < NC; k++) wv[k] = 0;
    wv[0] = 127; wv[1] = -128; wv[2] = 3; apply_w(); pix = 8'd255; pv = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (i == 783) begin
        expv = SW'(784 * 32385);
        chk("t4_784", NB'(num_b[SW-1:0]), NB'(expv));
      end
    end
    pv = 1'b0;
    chk("t4_posclamp", NB'(num_b[SW-1:0]), NB'(26'h1FFFFFF));
    chk("t4_negclamp", NB'(num_b[2*SW-1:SW]), NB'(26'h2000000));
    chk("t4_valid", NB'(nv_b), NB'(1));
    step();

    // restart from DONE; simultaneous beat must be dropped
    rand_beat(); pv = 1'b1; start = 2'b01;
    step(); start = '0;
    chk("t5_cleared", num_s, '0);
    for (int i = 0; i < 4; i++) begin rand_beat(); step(); end
    pv = 1'b0; step();

    // reset mid-run, stray beats, fresh run
    start = 2'b11; step(); start = '0; pv = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_beat(); step(); end
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_num", num_s, '0);
    for (int i = 0; i < 3; i++) begin rand_beat(); step(); end
    pv = 1'b0; start = 2'b01; step(); start = '0; pv = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_beat(); step(); end
    pv = 1'b0; step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_beat();
      rst   = ($urandom_range(299) == 0);
      start = {($urandom_range(99) == 0), ($urandom_range(5) == 0)};
      pv    = ($urandom_range(3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
